alu_issue_ctrl: RTL and testbench

Sequential issue/writeback controller that sits directly upstream of the 4-bit `ALU` and also consumes its output. It holds a 4-entry x 4-bit register file and accepts one instruction at a time over a valid/ready handshake. For each instruction it drives the ALU's `A`/`B`/`Opcode` from registers, captures `Result`/`CarryOut` into a destination register, and presents the result on a valid/ready output port. An external load port initialises the register file.

---
 rtl/alu_issue_ctrl.sv | 109 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for a combinational 4-bit ALU with a 4x4 register file.
// Latency: operands registered on accept, result and writeback one edge later (issue interval 3).
// Backpressure: result held stable in DONE until OutReady; no new instruction accepted meanwhile.
module alu_issue_ctrl #(
    parameter int NREG = 4,
    parameter int W    = 4
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         LoadEn,
    input  logic [1:0]   LoadAddr,
    input  logic [W-1:0] LoadData,
    input  logic         InstrValid,
    output logic         InstrReady,
    input  logic [2:0]   InstrOp,
    input  logic [1:0]   InstrDst,
    input  logic [1:0]   InstrSrcA,
    input  logic [1:0]   InstrSrcB,
    output logic [W-1:0] AluA,
    output logic [W-1:0] AluB,
    output logic [2:0]   AluOpcode,
    input  logic [W-1:0] AluResult,
    input  logic         AluCarryOut,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [W-1:0] OutData,
    output logic         OutCarry,
    output logic [1:0]   OutDst,
    output logic [7:0]   OpCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [W-1:0] rf [NREG];
    logic [W-1:0] opa_sel, opb_sel;
    logic         carry_op;

    always_comb begin
        state_nxt  = state;
        InstrReady = 1'b0;
        case (state)
            IDLE: begin
                InstrReady = 1'b1;
                if (InstrValid) state_nxt = EXEC;
            end
            EXEC: state_nxt = DONE;
            DONE: if (OutReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A load landing on the accept edge is forwarded straight into the operand.
    always_comb begin
        opa_sel = rf[InstrSrcA];
        opb_sel = rf[InstrSrcB];
        if (LoadEn && (LoadAddr == InstrSrcA)) opa_sel = LoadData;
        if (LoadEn && (LoadAddr == InstrSrcB)) opb_sel = LoadData;
    end

    assign carry_op = (AluOpcode == 3'b000) || (AluOpcode == 3'b001);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            AluA      <= '0;
            AluB      <= '0;
            AluOpcode <= 3'b000;
            OutValid  <= 1'b0;
            OutData   <= '0;
            OutCarry  <= 1'b0;
            OutDst    <= 2'd0;
            OpCount   <= 8'd0;
        end else begin
            state <= state_nxt;
            if (LoadEn) rf[LoadAddr] <= LoadData;
            case (state)
                IDLE: begin
                    if (InstrValid) begin
                        AluA      <= opa_sel;
                        AluB      <= opb_sel;
                        AluOpcode <= InstrOp;
                        OutDst    <= InstrDst;
                    end
                end
                EXEC: begin
                    // Issued after the load above, so writeback wins a same-register collision.
                    rf[OutDst] <= AluResult;
                    OutData    <= AluResult;
                    OutCarry   <= carry_op ? AluCarryOut : 1'b0;
                    OutValid   <= 1'b1;
                end
                DONE: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        OpCount  <= OpCount + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 4-bit ALU closing the loop.
module tb_alu_issue_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       LoadEn;
    logic [1:0] LoadAddr;
    logic [3:0] LoadData;
    logic       InstrValid;
    logic       InstrReady;
    logic [2:0] InstrOp;
    logic [1:0] InstrDst, InstrSrcA, InstrSrcB;
    logic [3:0] AluA, AluB;
    logic [2:0] AluOpcode;
    logic [3:0] AluResult;
    logic       AluCarryOut;
    logic       OutValid;
    logic       OutReady;
    logic [3:0] OutData;
    logic       OutCarry;
    logic [1:0] OutDst;
    logic [7:0] OpCount;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_cnt  = 8'd0;
    logic [3:0] rd;

    always #5 Clk = ~Clk;

    alu_issue_ctrl #(.NREG(4), .W(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
        .InstrValid(InstrValid), .InstrReady(InstrReady), .InstrOp(InstrOp),
        .InstrDst(InstrDst), .InstrSrcA(InstrSrcA), .InstrSrcB(InstrSrcB),
        .AluA(AluA), .AluB(AluB), .AluOpcode(AluOpcode),
        .AluResult(AluResult), .AluCarryOut(AluCarryOut),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .OutCarry(OutCarry), .OutDst(OutDst), .OpCount(OpCount)
    );

    // Behavioural ALU; shl reports the shifted-out bit so the carry gating is visible.
    always_comb begin
        AluResult   = 4'h0;
        AluCarryOut = 1'b0;
        case (AluOpcode)
            3'b000: {AluCarryOut, AluResult} = {1'b0, AluA} + {1'b0, AluB};
            3'b001: begin AluResult = AluA - AluB; AluCarryOut = (AluA < AluB); end
            3'b010: AluResult = AluA & AluB;
            3'b011: AluResult = AluA | AluB;
            3'b100: AluResult = AluA ^ AluB;
            3'b101: AluResult = ~AluA;
            3'b110: begin AluResult = AluA << 1; AluCarryOut = AluA[3]; end
            default: begin AluResult = AluA >> 1; AluCarryOut = AluA[0]; end
        endcase
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        LoadEn = 1'b1; LoadAddr = a; LoadData = d;
        step();
        LoadEn = 1'b0;
    endtask

    // Offers an instruction, accepts it, and stops one cycle into DONE with OutReady low.
    task automatic run_instr(input logic [2:0] op, input logic [1:0] dst,
                             input logic [1:0] sa, input logic [1:0] sb);
        OutReady = 1'b0;
        InstrValid = 1'b1; InstrOp = op; InstrDst = dst; InstrSrcA = sa; InstrSrcB = sb;
        chk("instr_ready_idle", {7'd0, InstrReady}, 8'd1);
        step();
        InstrValid = 1'b0;
        chk("alu_opcode", {5'd0, AluOpcode}, {5'd0, op});
        chk("out_valid_t0", {7'd0, OutValid}, 8'd0);
        chk("instr_ready_exec", {7'd0, InstrReady}, 8'd0);
        step();
        chk("out_valid_t1", {7'd0, OutValid}, 8'd1);
        chk("out_dst", {6'd0, OutDst}, {6'd0, dst});
    endtask

    task automatic finish_out();
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("out_valid_drop", {7'd0, OutValid}, 8'd0);
        chk("op_count", OpCount, exp_cnt);
        chk("instr_ready_back", {7'd0, InstrReady}, 8'd1);
    endtask

    task automatic read_reg(input logic [1:0] r, output logic [3:0] v);
        run_instr(3'b011, r, r, r);
        v = OutData;
        finish_out();
    endtask

    initial begin
        Rst = 1'b1; LoadEn = 1'b0; LoadAddr = 2'd0; LoadData = 4'h0;
        InstrValid = 1'b0; InstrOp = 3'b000; InstrDst = 2'd0;
        InstrSrcA = 2'd0; InstrSrcB = 2'd0; OutReady = 1'b0;
        step(); step();
        Rst = 1'b0;
        chk("rst_instr_ready", {7'd0, InstrReady}, 8'd1);
        chk("rst_out_valid", {7'd0, OutValid}, 8'd0);
        chk("rst_out_data", {4'd0, OutData}, 8'h00);
        chk("rst_op_count", OpCount, 8'd0);
        chk("rst_alu_a", {4'd0, AluA}, 8'h00);

        // 3 + 1 into R2
        load(2'd0, 4'b0011);
        load(2'd1, 4'b0001);
        run_instr(3'b000, 2'd2, 2'd0, 2'd1);
        chk("add_data", {4'd0, OutData}, 8'h04);
        chk("add_carry", {7'd0, OutCarry}, 8'd0);
        finish_out();
        read_reg(2'd2, rd);
        chk("r2_readback", {4'd0, rd}, 8'h04);

        // Overflow add, then xor, then shl whose ALU carry must be masked
        load(2'd0, 4'b1111);
        load(2'd1, 4'b0001);
        run_instr(3'b000, 2'd2, 2'd0, 2'd1);
        chk("add_ovf_data", {4'd0, OutData}, 8'h00);
        chk("add_ovf_carry", {7'd0, OutCarry}, 8'd1);
        finish_out();
        run_instr(3'b110, 2'd3, 2'd0, 2'd1);
        chk("shl_data", {4'd0, OutData}, 8'h0E);
        chk("shl_carry_masked", {7'd0, OutCarry}, 8'd0);
        finish_out();
        run_instr(3'b100, 2'd3, 2'd0, 2'd1);
        chk("xor_data", {4'd0, OutData}, 8'h0E);
        chk("xor_carry", {7'd0, OutCarry}, 8'd0);

        // Backpressure for 5 cycles in DONE
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {7'd0, OutValid}, 8'd1);
            chk("bp_data", {4'd0, OutData}, 8'h0E);
            chk("bp_ready", {7'd0, InstrReady}, 8'd0);
            chk("bp_count", OpCount, exp_cnt);
        end
        finish_out();

        // Same-edge load and writeback to R3: writeback wins
        load(2'd0, 4'b1000);
        load(2'd1, 4'b0100);
        InstrValid = 1'b1; InstrOp = 3'b011; InstrDst = 2'd3; InstrSrcA = 2'd0; InstrSrcB = 2'd1;
        step();
        InstrValid = 1'b0;
        LoadEn = 1'b1; LoadAddr = 2'd3; LoadData = 4'b0101;
        step();
        LoadEn = 1'b0;
        chk("coll_out_data", {4'd0, OutData}, 8'h0C);
        finish_out();
        read_reg(2'd3, rd);
        chk("coll_r3", {4'd0, rd}, 8'h0C);

        // Load forwarded into both operands on the accept edge
        LoadEn = 1'b1; LoadAddr = 2'd1; LoadData = 4'b0111;
        InstrValid = 1'b1; InstrOp = 3'b000; InstrDst = 2'd0; InstrSrcA = 2'd1; InstrSrcB = 2'd1;
        step();
        LoadEn = 1'b0; InstrValid = 1'b0;
        chk("fwd_alu_a", {4'd0, AluA}, 8'h07);
        chk("fwd_alu_b", {4'd0, AluB}, 8'h07);
        step();
        chk("fwd_data", {4'd0, OutData}, 8'h0E);
        finish_out();
        read_reg(2'd1, rd);
        chk("fwd_r1", {4'd0, rd}, 8'h07);

        // Reset while in EXEC discards the writeback to R2
        InstrValid = 1'b1; InstrOp = 3'b011; InstrDst = 2'd2; InstrSrcA = 2'd1; InstrSrcB = 2'd1;
        step();
        InstrValid = 1'b0;
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        exp_cnt = 8'd0;
        chk("mid_rst_valid", {7'd0, OutValid}, 8'd0);
        chk("mid_rst_data", {4'd0, OutData}, 8'h00);
        chk("mid_rst_carry", {7'd0, OutCarry}, 8'd0);
        chk("mid_rst_dst", {6'd0, OutDst}, 8'd0);
        chk("mid_rst_alu_a", {4'd0, AluA}, 8'h00);
        chk("mid_rst_alu_b", {4'd0, AluB}, 8'h00);
        chk("mid_rst_opcode", {5'd0, AluOpcode}, 8'd0);
        chk("mid_rst_count", OpCount, 8'd0);
        chk("mid_rst_ready", {7'd0, InstrReady}, 8'd1);
        read_reg(2'd2, rd);
        chk("mid_rst_r2", {4'd0, rd}, 8'h00);

        // Run the completion counter through 255 and wrap
        load(2'd0, 4'b0001);
        while (exp_cnt != 8'd255) begin
            run_instr(3'b000, 2'd1, 2'd0, 2'd0);
            finish_out();
        end
        chk("count_255", OpCount, 8'd255);
        run_instr(3'b000, 2'd1, 2'd0, 2'd0);
        finish_out();
        chk("count_wrap", OpCount, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
